// File: rtl/icache_line_refill_responder.sv
// Instruction-cache line refill responder: reads one line from synchronous memory
// and returns it critical word first through a 2-entry response buffer.
module icache_line_refill_responder #(
  parameter int unsigned LINE_BYTES = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [ADDR_WIDTH-1:0]           req_addr_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [31:0]                     rsp_data_o,
  output logic [$clog2(LINE_BYTES/4)-1:0] rsp_beat_o,
  output logic                            rsp_last_o,
  output logic                            mem_re_o,
  output logic [ADDR_WIDTH-1:0]           mem_addr_o,
  input  logic [31:0]                     mem_rdata_i
);

  localparam int unsigned BEATS  = LINE_BYTES / 4;
  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned OFF_W  = $clog2(LINE_BYTES);
  localparam int unsigned BASE_W = ADDR_WIDTH - OFF_W;
  localparam int unsigned CNT_W  = IDX_W + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  start_q, start_d;
  logic [CNT_W-1:0]  issue_cnt_q, issue_cnt_d;
  logic [IDX_W-1:0]  accept_cnt_q, accept_cnt_d;
  logic              inflight_q, inflight_d;
  logic [IDX_W-1:0]  infl_idx_q, infl_idx_d;
  logic              infl_last_q, infl_last_d;
  logic [31:0]       fifo_data_q [2];
  logic [31:0]       fifo_data_d [2];
  logic [IDX_W-1:0]  fifo_idx_q [2];
  logic [IDX_W-1:0]  fifo_idx_d [2];
  logic [1:0]        fifo_last_q, fifo_last_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;

  logic              pop;
  logic              issue;
  logic              credit_ok;
  logic [2:0]        committed;
  logic [IDX_W-1:0]  issue_idx;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^req_addr_i[1:0];

  // Response side is driven straight from the buffer head and blanked during reset
  assign req_ready_o = !rst_i && (state_q == ST_IDLE);
  assign rsp_valid_o = !rst_i && (occ_q != 2'd0);
  assign rsp_data_o  = rst_i ? 32'd0 : fifo_data_q[rd_ptr_q];
  assign rsp_beat_o  = rst_i ? '0 : fifo_idx_q[rd_ptr_q];
  assign rsp_last_o  = !rst_i && fifo_last_q[rd_ptr_q];

  assign pop = rsp_valid_o && rsp_ready_i;

  // Buffered plus in-flight beats must stay below two after this cycle's pop
  assign committed = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
  assign credit_ok = committed < 3'd2;
  assign issue     = !rst_i && (state_q == ST_BURST) &&
                     (issue_cnt_q < CNT_W'(BEATS)) && credit_ok;
  assign issue_idx = start_q + issue_cnt_q[IDX_W-1:0];

  assign mem_re_o   = issue;
  assign mem_addr_o = issue ? {base_q, issue_idx, 2'b00} : '0;

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    start_d      = start_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    inflight_d   = issue;
    infl_idx_d   = issue_idx;
    infl_last_d  = (issue_cnt_q == CNT_W'(BEATS - 1));
    fifo_data_d  = fifo_data_q;
    fifo_idx_d   = fifo_idx_q;
    fifo_last_d  = fifo_last_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    occ_d        = occ_q + 2'(inflight_q) - 2'(pop);

    case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          base_d       = req_addr_i[ADDR_WIDTH-1:OFF_W];
          start_d      = req_addr_i[OFF_W-1:2];
          issue_cnt_d  = '0;
          accept_cnt_d = '0;
          state_d      = ST_BURST;
        end
      end
      ST_BURST: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CNT_W'(1);
        end
        if (pop) begin
          accept_cnt_d = accept_cnt_q + IDX_W'(1);
          if (accept_cnt_q == IDX_W'(BEATS - 1)) begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read data lands one cycle after its issue
    if (inflight_q) begin
      fifo_data_d[wr_ptr_q] = mem_rdata_i;
      fifo_idx_d[wr_ptr_q]  = infl_idx_q;
      fifo_last_d[wr_ptr_q] = infl_last_q;
      wr_ptr_d              = !wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = !rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      start_q      <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      inflight_q   <= 1'b0;
      infl_idx_q   <= '0;
      infl_last_q  <= 1'b0;
      fifo_data_q  <= '{default: '0};
      fifo_idx_q   <= '{default: '0};
      fifo_last_q  <= '0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_q      <= start_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      inflight_q   <= inflight_d;
      infl_idx_q   <= infl_idx_d;
      infl_last_q  <= infl_last_d;
      fifo_data_q  <= fifo_data_d;
      fifo_idx_q   <= fifo_idx_d;
      fifo_last_q  <= fifo_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
    end
  end

endmodule

// File: tb/tb_icache_line_refill_responder.sv
// Directed-plus-random bench for the refill responder against a line-order reference model.
module tb_icache_line_refill_responder;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [3:0]  rsp_beat_o;
  logic        rsp_last_o;
  logic        mem_re_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_rdata_i;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] key = 32'hA5A5A5A5;

  icache_line_refill_responder dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_addr_i (req_addr_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_beat_o (rsp_beat_o),
    .rsp_last_o (rsp_last_o),
    .mem_re_o   (mem_re_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word content is address ^ key; garbage when not read
  always @(posedge clk) mem_rdata_i <= mem_re_o ? (mem_addr_o ^ key) : $urandom;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0: always ready; 1: ready ~1 in 3; 2: ready only in cycle 1 then from cycle 14
  task automatic run_burst(input logic [31:0] addr, input int mode, input int abort_at,
                           input bit hold, input logic [31:0] next_addr, output int waited);
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [3:0]  got_beat[$];
    logic        got_last[$];
    int          issued, accepted, first_valid, last_cyc, start_w;
    bit          stalled, done, pop;
    logic [31:0] s_data, e_addr;
    logic [3:0]  s_beat;
    logic        s_last;

    start_w = int'(addr[5:2]);
    req_valid_i = 1'b1;
    req_addr_i  = addr;
    rsp_ready_i = 1'b1;
    waited = 0;
    forever begin
      @(negedge clk);
      if (req_ready_o || waited > 60) break;
      @(posedge clk); #1;
      waited++;
    end
    chk("req_accept", req_ready_o, 1);
    @(posedge clk); #1;
    if (hold) req_addr_i = next_addr;
    else req_valid_i = 1'b0;

    issued = 0; accepted = 0; first_valid = -1; last_cyc = -1;
    stalled = 0; done = 0; s_data = '0; s_beat = '0; s_last = 1'b0;
    for (int cyc = 1; cyc < 300 && !done; cyc++) begin
      case (mode)
        0:       rsp_ready_i = 1'b1;
        1:       rsp_ready_i = ($urandom_range(0, 2) == 0);
        default: rsp_ready_i = (cyc < 2 || cyc >= 14);
      endcase
      @(negedge clk);
      pop = rsp_valid_o && rsp_ready_i;
      if (stalled) begin
        chk("stall_valid", rsp_valid_o, 1);
        chk("stall_data", rsp_data_o, s_data);
        chk("stall_beat", rsp_beat_o, s_beat);
        chk("stall_last", rsp_last_o, s_last);
      end
      if (rsp_valid_o && first_valid < 0) first_valid = cyc;
      if (mem_re_o) begin
        chk("credit", ((issued - accepted - int'(pop)) < 2), 1);
        got_addr.push_back(mem_addr_o);
        issued++;
      end
      if (hold) chk("req_held_off", req_ready_o, 0);
      if (mode == 2 && cyc == 13) chk("stall_issue_count", issued, 2);
      if (pop) begin
        got_data.push_back(rsp_data_o);
        got_beat.push_back(rsp_beat_o);
        got_last.push_back(rsp_last_o);
        accepted++;
        if (rsp_last_o) begin
          last_cyc = cyc;
          done = 1;
        end
        if (abort_at > 0 && accepted == abort_at) done = 1;
      end
      stalled = rsp_valid_o && !rsp_ready_i;
      s_data = rsp_data_o; s_beat = rsp_beat_o; s_last = rsp_last_o;
      @(posedge clk); #1;
    end
    if (!done) chk("burst_timeout", 0, 1);
    if (abort_at > 0) return;

    chk("issue_count", got_addr.size(), 16);
    chk("beat_count", got_data.size(), 16);
    for (int i = 0; i < 16; i++) begin
      e_addr = (addr & ~32'h3F) + 32'(((start_w + i) % 16) * 4);
      if (i < got_addr.size()) chk("mem_addr", got_addr[i], e_addr);
      if (i < got_data.size()) begin
        chk("beat_idx", got_beat[i], 32'((start_w + i) % 16));
        chk("beat_data", got_data[i], e_addr ^ key);
        chk("beat_last", got_last[i], (i == 15));
      end
    end
    if (mode == 0) begin
      chk("first_valid_cycle", first_valid, 3);
      chk("last_beat_cycle", last_cyc, 18);
    end
  endtask

  initial begin
    int w;
    rst_i = 1'b1; req_valid_i = 1'b0; req_addr_i = '0; rsp_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_mem_re", mem_re_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", req_ready_o, 1);
    chk("post_rst_rsp_valid", rsp_valid_o, 0);
    chk("post_rst_rsp_last", rsp_last_o, 0);
    chk("post_rst_rsp_beat", rsp_beat_o, 0);
    @(posedge clk); #1;

    // Aligned fill and critical-word wrap
    key = 32'hA5A5A5A5;
    run_burst(32'h0000_1000, 0, 0, 1'b0, '0, w);
    run_burst(32'h0000_1036, 0, 0, 1'b0, '0, w);

    // Random backpressure, random addresses and data keys
    for (int t = 0; t < 3; t++) begin
      key = $urandom;
      run_burst($urandom, 1, 0, 1'b0, '0, w);
    end

    // Back-to-back requests with RequestValid held
    key = $urandom;
    run_burst(32'h0000_2000, 0, 0, 1'b1, 32'h0000_3010, w);
    run_burst(32'h0000_3010, 0, 0, 1'b0, '0, w);
    chk("b2b_accept_wait", w, 0);

    // Reset after five beats accepted
    run_burst(32'h0000_5000, 0, 5, 1'b0, '0, w);
    rst_i = 1'b1;
    @(negedge clk);
    chk("midrst_req_ready", req_ready_o, 0);
    chk("midrst_mem_re", mem_re_o, 0);
    chk("midrst_rsp_valid", rsp_valid_o, 0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("after_rst_rsp_valid", rsp_valid_o, 0);
    chk("after_rst_mem_re", mem_re_o, 0);
    chk("after_rst_req_ready", req_ready_o, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("stale_not_enqueued", rsp_valid_o, 0);
    @(posedge clk); #1;
    run_burst(32'h0000_4000, 0, 0, 1'b0, '0, w);

    // Long stall from cycle 2
    key = $urandom;
    run_burst(32'h0000_6020, 2, 0, 1'b0, '0, w);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/icache_line_refill_responder.md
Name: icache_line_refill_responder

Overview:
- Memory-side responder for instruction-cache line refills.
- Accepts one line-fill request at a time and reads the 64-byte line from a synchronous backing memory.
- Returns the line as 16 32-bit beats, critical word first, wrapping within the line.
- Sits between the instruction cache miss path and the instruction memory; a 2-entry output buffer absorbs response backpressure.

Parameters:
- LINE_BYTES, 64, bytes per cache line. Beats per line = LINE_BYTES/4 = 16. Must be a power of two, at least 8.
- ADDR_WIDTH, 32, byte-address width of the request and memory addresses.

Ports:
- Clock  input  1  single system clock; all logic on its rising edge.
- Reset  input  1  synchronous, active-high reset.
- RequestValid  input  1  line-fill request present.
- RequestReady  output  1  responder can accept a request; high only in IDLE with Reset low.
- RequestAddress  input  ADDR_WIDTH  byte address of the missed instruction. Bits [5:2] select the critical word; bits [1:0] are ignored.
- ResponseValid  output  1  ResponseData/ResponseBeat/ResponseLast are valid.
- ResponseReady  input  1  consumer accepts the current beat.
- ResponseData  output  32  instruction word.
- ResponseBeat  output  4  word index within the line (0..15) of the current beat.
- ResponseLast  output  1  high on the 16th beat of a burst.
- MemReadEnable  output  1  issue a read to the backing memory this cycle.
- MemAddress  output  ADDR_WIDTH  word-aligned read address; bits [1:0] always 0.
- MemReadData  input  32  read data, valid exactly one cycle after MemReadEnable.

Behaviour:
- States: IDLE, BURST.
- Reset (synchronous, active-high):
  - state goes to IDLE; issue count, accept count, FIFO pointers and occupancy, and the in-flight flag are all cleared.
  - Outputs during and immediately after reset: RequestReady=0 while Reset is high, ResponseValid=0, MemReadEnable=0, ResponseLast=0, ResponseData=0, ResponseBeat=0, MemAddress=0.
- IDLE:
  - RequestReady=1.
  - On RequestValid&&RequestReady: latch LineBase=RequestAddress[ADDR_WIDTH-1:6] and StartWord=RequestAddress[5:2]; clear IssueCount and AcceptCount; go to BURST.
- BURST:
  - RequestReady=0; requests are held off and not dropped.
  - Read issue: MemReadEnable=1 when IssueCount<16 and (occupancy + inflight - pop) < 2, where pop = ResponseValid&&ResponseReady this cycle.
  - Read address: MemAddress={LineBase, (StartWord+IssueCount) mod 16, 2'b00}. The word index wraps modulo 16; the line base never increments.
  - Each issued read increments IssueCount and sets the in-flight flag for the next cycle.
- Return path:
  - In the cycle after an issue, MemReadData is written into the 2-entry FIFO along with its word index and a last flag (last = the 16th issue).
  - FIFO write and pop in the same cycle are legal; occupancy is unchanged.
  - The FIFO can never overflow, because the credit rule above guarantees it.
- Response side:
  - ResponseValid = FIFO non-empty; outputs are driven from the FIFO head.
  - While ResponseValid&&!ResponseReady, ResponseData/ResponseBeat/ResponseLast hold stable.
- Burst end: on the handshake with ResponseLast=1, go to IDLE. RequestReady is high the following cycle.
- Latency, with ResponseReady held high:
  - Request handshake in cycle 0; first MemReadEnable in cycle 1; first ResponseValid in cycle 3.
  - One beat per cycle after that; last beat in cycle 18; next request accepted no earlier than cycle 19.
- Beat order: StartWord, StartWord+1, ..., 15, 0, ..., StartWord-1. ResponseLast is based on count, not on index.
- Reset mid-burst: the burst is abandoned and buffered and in-flight data discarded. MemReadData arriving in the cycle after Reset deasserts is ignored.
- Memory and response sides have no combinational path from ResponseReady to ResponseData. MemReadEnable may depend combinationally on ResponseReady through the credit rule.

Test Plan:
1. Aligned fill: request 0x0000_1000 with ResponseReady=1 and memory data=address^0xA5A5A5A5.
   -> MemAddress 0x1000..0x103C on consecutive cycles; beats 0..15 carry the correct data; first ResponseValid 3 cycles after the handshake; ResponseLast on beat 15 in cycle 18.
2. Critical-word wrap: request 0x0000_1036.
   -> MemAddress 0x1034, 0x1038, 0x103C, 0x1000, ..., 0x1030; ResponseBeat 13,14,15,0..12; ResponseLast with ResponseBeat=12; exactly 16 beats.
3. Backpressure: ResponseReady high 1 cycle in 3, random pattern.
   -> no beat lost or duplicated; outputs stable while stalled; MemReadEnable low whenever 2 entries are buffered or in flight; still exactly 16 beats in order.
4. Back-to-back: RequestValid held high with 0x2000 followed by 0x3010.
   -> RequestReady low throughout the first burst; the second request is accepted the cycle after the first ResponseLast handshake; the second burst starts at word 4 of line 0x3000.
5. Reset mid-burst: assert Reset for 1 cycle after 5 beats are accepted.
   -> the next cycle shows ResponseValid=0, MemReadEnable=0, RequestReady=1; stale read data is not enqueued; a new request to 0x4000 returns a clean 16-beat burst.
6. Continuous stalls at end: ResponseReady=0 from cycle 2 onward.
   -> exactly 2 reads are issued, then MemReadEnable stays 0; after ResponseReady rises, all 16 beats complete in order.
